// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit path.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE,
    ST_ERROR
  } state_e;

  localparam logic [1:0]  ERR_NONE    = 2'b00;
  localparam logic [1:0]  ERR_TIMEOUT = 2'b01;
  localparam logic [1:0]  ERR_NOACK   = 2'b10;
  localparam int unsigned FRAME_BITS  = 10;
  localparam int unsigned ACK_FALL    = 11;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command/status handshake between a client and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_error;
  logic [1:0] err_code;

  modport master (
    output cmd_data, cmd_valid,
    input  cmd_ready, busy, tx_done, tx_error, err_code
  );

  modport slave (
    input  cmd_data, cmd_valid,
    output cmd_ready, busy, tx_done, tx_error, err_code
  );
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for one PS/2 line plus a registered falling-edge strobe.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic level,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Idle bus level is high, so reset to 1 to avoid a spurious fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
      fall <= 1'b0;
    end else begin
      meta <= line;
      sync <= meta;
      prev <= sync;
      fall <= prev & ~sync;
    end
  end

  assign level = sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, clocked frame, ACK check.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
  parameter int unsigned INHIBIT_CYCLES = CLK_FREQ_HZ / 10_000,
  parameter int unsigned REQ_CYCLES     = CLK_FREQ_HZ / 500_000,
  parameter int unsigned TIMEOUT_CYCLES = (CLK_FREQ_HZ / 1_000) * 15
) (
  input  logic          clk,
  input  logic          resetn,
  ps2_host_tx_if.slave  bus,
  input  logic          ps2_clk_in,
  input  logic          ps2_dat_in,
  output logic          ps2_clk_oe,
  output logic          ps2_dat_oe
);

  localparam int unsigned CNT_W = $clog2(max3(INHIBIT_CYCLES, REQ_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] REQ_LAST = CNT_W'(REQ_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic clk_lvl, clk_fall;
  logic dat_lvl, dat_fall_unused;

  ps2_line_sync u_clk_sync (
    .clk   (clk),
    .rst_n (resetn),
    .line  (ps2_clk_in),
    .level (clk_lvl),
    .fall  (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clk   (clk),
    .rst_n (resetn),
    .line  (ps2_dat_in),
    .level (dat_lvl),
    .fall  (dat_fall_unused)
  );

  state_e                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [3:0]            bit_cnt, bit_cnt_n;
  logic [FRAME_BITS-1:0] frame, frame_n;
  logic                  dat_oe_n;
  logic [1:0]            err_code_n;
  logic                  done_n;

  // Next-state, counters and line drive.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_cnt_n  = bit_cnt;
    frame_n    = frame;
    dat_oe_n   = ps2_dat_oe;
    err_code_n = bus.err_code;
    done_n     = 1'b0;

    unique case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (bus.cmd_valid && bus.cmd_ready) begin
          state_n = ST_INHIBIT;
          frame_n = {1'b1, ~^bus.cmd_data, bus.cmd_data};
        end
      end
      ST_INHIBIT: begin
        if (cnt == INH_LAST) begin
          state_n  = ST_REQ;
          cnt_n    = '0;
          dat_oe_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_REQ: begin
        if (cnt == REQ_LAST) begin
          state_n   = ST_SEND;
          cnt_n     = '0;
          bit_cnt_n = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_SEND: begin
        if (clk_fall) begin
          cnt_n     = '0;
          dat_oe_n  = ~frame[bit_cnt];
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt == 4'(FRAME_BITS - 1)) state_n = ST_ACK;
        end else if (cnt == TO_LAST) begin
          state_n    = ST_ERROR;
          err_code_n = ERR_TIMEOUT;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_ACK: begin
        if (clk_fall) begin
          cnt_n     = '0;
          bit_cnt_n = 4'(ACK_FALL);
          if (dat_lvl) begin
            state_n    = ST_ERROR;
            err_code_n = ERR_NOACK;
          end else begin
            state_n = ST_WAIT_IDLE;
          end
        end else if (cnt == TO_LAST) begin
          state_n    = ST_ERROR;
          err_code_n = ERR_TIMEOUT;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_lvl && dat_lvl) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end else if (clk_fall) begin
          cnt_n = '0;
        end else if (cnt == TO_LAST) begin
          state_n    = ST_ERROR;
          err_code_n = ERR_TIMEOUT;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_ERROR: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase

    // Data is only ever pulled low from the start bit through the stop bit.
    if (state_n inside {ST_IDLE, ST_INHIBIT, ST_ACK, ST_WAIT_IDLE, ST_ERROR}) dat_oe_n = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      frame         <= '0;
      ps2_clk_oe    <= 1'b0;
      ps2_dat_oe    <= 1'b0;
      bus.cmd_ready <= 1'b1;
      bus.busy      <= 1'b0;
      bus.tx_done   <= 1'b0;
      bus.tx_error  <= 1'b0;
      bus.err_code  <= ERR_NONE;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      bit_cnt       <= bit_cnt_n;
      frame         <= frame_n;
      ps2_clk_oe    <= (state_n == ST_INHIBIT) || (state_n == ST_REQ);
      ps2_dat_oe    <= dat_oe_n;
      bus.cmd_ready <= (state_n == ST_IDLE);
      bus.busy      <= (state_n != ST_IDLE);
      bus.tx_done   <= done_n;
      bus.tx_error  <= (state_n == ST_ERROR);
      bus.err_code  <= err_code_n;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;

  localparam int unsigned INH = 5000;
  localparam int unsigned REQ = 100;
  localparam int unsigned TO  = 2000;
  localparam int unsigned H   = 25;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic ps2_clk_oe, ps2_dat_oe;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic line_clk, line_dat;

  assign line_clk = ~(ps2_clk_oe | dev_clk_low);
  assign line_dat = ~(ps2_dat_oe | dev_dat_low);

  ps2_host_tx_if bus();

  ps2_host_tx #(
    .CLK_FREQ_HZ    (50_000_000),
    .INHIBIT_CYCLES (INH),
    .REQ_CYCLES     (REQ),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus),
    .ps2_clk_in (line_clk),
    .ps2_dat_in (line_dat),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse monitors
  int   done_cnt = 0;
  int   err_cnt  = 0;
  int   both_cnt = 0;
  logic done_prev = 1'b0;
  logic busy_after_done = 1'b0;

  always @(negedge clk) begin
    if (bus.tx_done === 1'b1) done_cnt++;
    if (bus.tx_error === 1'b1) err_cnt++;
    if (bus.tx_done === 1'b1 && bus.tx_error === 1'b1) both_cnt++;
    if (done_prev === 1'b1) busy_after_done = bus.busy;
    done_prev = bus.tx_done;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue(input logic [7:0] d);
    @(negedge clk);
    bus.cmd_data  = d;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic measure_req(output int inh, output int req);
    inh = 0;
    while (ps2_clk_oe && !ps2_dat_oe && inh < 20000) begin
      inh++;
      @(negedge clk);
    end
    req = 0;
    while (ps2_clk_oe && ps2_dat_oe && req < 1000) begin
      req++;
      @(negedge clk);
    end
  endtask

  // Device: waits for request-to-send, clocks 11 pulses, samples on rising edges, ACKs on clock 11.
  task automatic device(input bit ack, input int abort_at, output logic [9:0] bits, output bit started);
    int t;
    t = 0;
    started = 1'b0;
    bits = '0;
    while (!(line_clk && !line_dat) && t < 10000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 10000) return;
    started = 1'b1;
    wait_cyc(20);
    for (int i = 1; i <= 11; i++) begin
      dev_clk_low = 1'b1;
      if (i == abort_at) return;
      wait_cyc(H);
      if (i <= 10) bits[i-1] = line_dat;
      dev_clk_low = 1'b0;
      if (i == 10 && ack) dev_dat_low = 1'b1;
      if (i == 11) dev_dat_low = 1'b0;
      wait_cyc(H);
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input logic par, input bit ack);
    int inh, req, d0, e0;
    logic [9:0] bits;
    bit started;
    d0 = done_cnt;
    e0 = err_cnt;
    issue(d);
    check("busy_on_accept", bus.busy, 1);
    check("ready_low_on_accept", bus.cmd_ready, 0);
    measure_req(inh, req);
    check("inhibit_len", inh, INH);
    check("req_len", req, REQ);
    device(ack, 0, bits, started);
    check("dev_started", started, 1);
    check("dev_byte", bits[7:0], d);
    check("dev_parity", bits[8], par);
    check("dev_stop", bits[9], 1);
    wait_cyc(20);
    if (ack) begin
      check("done_pulses", done_cnt - d0, 1);
      check("err_pulses", err_cnt - e0, 0);
      check("ready_after_done", bus.cmd_ready, 1);
      check("busy_after_done", bus.busy, 0);
    end else begin
      check("noack_err_pulses", err_cnt - e0, 1);
      check("noack_done_pulses", done_cnt - d0, 0);
      check("noack_err_code", bus.err_code, 2'b10);
      check("noack_clk_oe", ps2_clk_oe, 0);
      check("noack_dat_oe", ps2_dat_oe, 0);
    end
  endtask

  initial begin
    int inh, req, t, d0, e0;
    logic [9:0] bits;
    bit started;

    bus.cmd_data  = 8'h00;
    bus.cmd_valid = 1'b0;
    wait_cyc(4);
    resetn = 1'b1;
    wait_cyc(2);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_tx_done", bus.tx_done, 0);
    check("rst_tx_error", bus.tx_error, 0);
    check("rst_err_code", bus.err_code, 2'b00);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_dat_oe", ps2_dat_oe, 0);

    run_frame(8'hED, 1'b1, 1'b1);
    run_frame(8'h01, 1'b0, 1'b1);
    run_frame(8'h00, 1'b1, 1'b1);
    run_frame(8'hFF, 1'b1, 1'b1);
    run_frame(8'h3C, 1'b1, 1'b0);

    // No device clock after request
    d0 = done_cnt;
    e0 = err_cnt;
    issue(8'hA5);
    measure_req(inh, req);
    check("to_req_len", req, REQ);
    t = 0;
    while (bus.tx_error !== 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("to_latency_in_window", (t >= int'(TO) - 3) && (t <= int'(TO) + 3), 1);
    check("to_err_code", bus.err_code, 2'b01);
    check("to_clk_oe", ps2_clk_oe, 0);
    check("to_dat_oe", ps2_dat_oe, 0);
    wait_cyc(5);
    check("to_err_pulses", err_cnt - e0, 1);
    check("to_done_pulses", done_cnt - d0, 0);

    // Reset during inhibit releases the clock line immediately
    issue(8'h12);
    wait_cyc(100);
    check("inh_clk_oe_before_rst", ps2_clk_oe, 1);
    #2 resetn = 1'b0;
    #1 check("inh_rst_clk_oe", ps2_clk_oe, 0);
    wait_cyc(3);
    resetn = 1'b1;
    wait_cyc(2);

    // Reset after the 4th fall: D3 of 'hE5 is 0, so data is being pulled low
    issue(8'hE5);
    measure_req(inh, req);
    device(1'b1, 4, bits, started);
    wait_cyc(6);
    check("mid_dat_oe_before_rst", ps2_dat_oe, 1);
    #2 resetn = 1'b0;
    #1 check("mid_rst_clk_oe", ps2_clk_oe, 0);
    check("mid_rst_dat_oe", ps2_dat_oe, 0);
    dev_clk_low = 1'b0;
    wait_cyc(3);
    resetn = 1'b1;
    wait_cyc(2);
    check("mid_ready_after_rst", bus.cmd_ready, 1);
    check("mid_busy_after_rst", bus.busy, 0);
    run_frame(8'hFF, 1'b1, 1'b1);

    // cmd_valid held with 'h55 while 'hED is in flight
    d0 = done_cnt;
    @(negedge clk);
    bus.cmd_data  = 8'hED;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_data  = 8'h55;
    check("q_busy", bus.busy, 1);
    measure_req(inh, req);
    device(1'b1, 0, bits, started);
    check("q_first_byte", bits[7:0], 8'hED);
    check("q_first_done", done_cnt - d0, 1);
    check("q_accept_first_idle", busy_after_done, 1);
    bus.cmd_valid = 1'b0;
    check("q_second_busy", bus.busy, 1);
    measure_req(inh, req);
    device(1'b1, 0, bits, started);
    check("q_second_byte", bits[7:0], 8'h55);
    check("q_second_parity", bits[8], 1);
    wait_cyc(20);
    check("q_total_done", done_cnt - d0, 2);
    check("q_ready_end", bus.cmd_ready, 1);

    check("done_error_exclusive", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
